// File: rtl/ssd_scan_decoder.sv
// Observes a multiplexed seven-segment scan (Segment/Digital pins) and rebuilds
// the 32-bit SSDC word once per complete digit 0..5 frame, published over valid/ready.
module ssd_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Segment,
    input  logic [5:0]  Digital,
    output logic [31:0] FrameData,
    output logic        FrameValid,
    input  logic        FrameReady,
    output logic        Overrun
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] DISABLED_WORD = 32'h00FF_FFFF;
    localparam logic [5:0]  DIGIT0_SEL    = 6'b111110;

    typedef enum logic {HUNT, CAPTURE} scanStateT;

    scanStateT state, stateNext;

    logic [7:0]        segMeta, segSync, segPrev;
    logic [5:0]        digMeta, digSync, digPrev;
    logic [CNT_W-1:0]  stableCnt;
    logic [IDLE_W-1:0] idleCnt;
    logic              slotDone;

    logic [23:0] nibAcc, nibMerged;
    logic [5:0]  dpAcc, dpMerged;
    logic        errAcc;
    logic [2:0]  expected;

    logic        sampleSame, digChange, stableHit, timeoutHit;
    logic [4:0]  curDecode;
    logic [3:0]  curNib;
    logic        curErr, curDp, selOneHot;
    logic [2:0]  selIdx;
    logic        loadFirst, loadNext, publish;
    logic [31:0] publishWord;

    // Low-active segment code to {error, nibble}
    function automatic logic [4:0] decodeSeg(input logic [6:0] code);
        case (code)
            7'h40:   decodeSeg = 5'h00;
            7'h79:   decodeSeg = 5'h01;
            7'h24:   decodeSeg = 5'h02;
            7'h30:   decodeSeg = 5'h03;
            7'h19:   decodeSeg = 5'h04;
            7'h12:   decodeSeg = 5'h05;
            7'h02:   decodeSeg = 5'h06;
            7'h78:   decodeSeg = 5'h07;
            7'h00:   decodeSeg = 5'h08;
            7'h10:   decodeSeg = 5'h09;
            7'h7F:   decodeSeg = 5'h0F;
            default: decodeSeg = 5'h1E;
        endcase
    endfunction

    function automatic logic [2:0] selToIdx(input logic [5:0] sel);
        selToIdx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!sel[i]) selToIdx = 3'(i);
        end
    endfunction

    // Two-flop synchronizers plus one more stage for change detection
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            segMeta <= '1;
            segSync <= '1;
            segPrev <= '1;
            digMeta <= '1;
            digSync <= '1;
            digPrev <= '1;
        end else begin
            segMeta <= Segment;
            segSync <= segMeta;
            segPrev <= segSync;
            digMeta <= Digital;
            digSync <= digMeta;
            digPrev <= digSync;
        end
    end

    assign sampleSame = (segSync == segPrev) && (digSync == digPrev);
    assign digChange  = (digSync != digPrev);
    assign stableHit  = (stableCnt == CNT_W'(STABLE_CYCLES - 1)) && !slotDone;
    assign timeoutHit = (idleCnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Stability and idle counters; slotDone limits acceptance to once per select
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stableCnt <= '0;
            idleCnt   <= '0;
            slotDone  <= 1'b0;
        end else begin
            if (!sampleSame)
                stableCnt <= '0;
            else if (stableCnt != '1)
                stableCnt <= stableCnt + CNT_W'(1);

            if (digChange)
                idleCnt <= '0;
            else if (idleCnt != IDLE_W'(TIMEOUT_CYCLES))
                idleCnt <= idleCnt + IDLE_W'(1);

            if (digChange)
                slotDone <= 1'b0;
            else if (stableHit)
                slotDone <= 1'b1;
        end
    end

    assign curDecode = decodeSeg(segPrev[6:0]);
    assign curNib    = curDecode[3:0];
    assign curErr    = curDecode[4];
    assign curDp     = ~segPrev[7];
    assign selOneHot = $onehot(~digPrev);
    assign selIdx    = selToIdx(digPrev);

    // Partial frame with the current digit inserted at its slot
    always_comb begin
        nibMerged = nibAcc;
        dpMerged  = dpAcc;
        for (int i = 0; i < 6; i++) begin
            if (selIdx == 3'(i)) begin
                nibMerged[4*i +: 4] = curNib;
                dpMerged[i]         = curDp;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= HUNT;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        loadFirst   = 1'b0;
        loadNext    = 1'b0;
        publish     = 1'b0;
        publishWord = DISABLED_WORD;
        if (timeoutHit) begin
            publish   = 1'b1;
            stateNext = HUNT;
        end else if (stableHit) begin
            case (state)
                HUNT: begin
                    if (digPrev == DIGIT0_SEL) begin
                        loadFirst = 1'b1;
                        stateNext = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (selOneHot && (selIdx == expected)) begin
                        if (expected == 3'd5) begin
                            publish     = 1'b1;
                            publishWord = {1'b1, errAcc | curErr, dpMerged, nibMerged};
                            stateNext   = HUNT;
                        end else begin
                            loadNext = 1'b1;
                        end
                    end else if (digPrev == DIGIT0_SEL) begin
                        // Out-of-order select restarts the frame if it is digit 0
                        loadFirst = 1'b1;
                    end else begin
                        stateNext = HUNT;
                    end
                end
                default: stateNext = HUNT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            nibAcc   <= '0;
            dpAcc    <= '0;
            errAcc   <= 1'b0;
            expected <= '0;
        end else if (loadFirst) begin
            nibAcc   <= {20'h0, curNib};
            dpAcc    <= {5'b0, curDp};
            errAcc   <= curErr;
            expected <= 3'd1;
        end else if (loadNext) begin
            nibAcc   <= nibMerged;
            dpAcc    <= dpMerged;
            errAcc   <= errAcc | curErr;
            expected <= expected + 3'd1;
        end
    end

    // Output handshake; a publish into a stalled slot is dropped and flagged
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            FrameData  <= DISABLED_WORD;
            FrameValid <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            if (publish && (!FrameValid || FrameReady)) begin
                FrameData  <= publishWord;
                FrameValid <= 1'b1;
            end else if (FrameValid && FrameReady) begin
                FrameValid <= 1'b0;
            end

            if (publish && FrameValid && !FrameReady)
                Overrun <= 1'b1;
            else if (FrameValid && FrameReady)
                Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: drives SSDC-style scans and checks every
// transferred frame against a word-level model of the display contents.
module tb_ssd_scan_decoder;

    localparam int unsigned STABLE  = 16;
    localparam int unsigned TIMEOUT = 1000;
    localparam int          SLOT    = 100;
    localparam logic [6:0]  SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        Clock;
    logic        Reset;
    logic [7:0]  Segment;
    logic [5:0]  Digital;
    logic [31:0] FrameData;
    logic        FrameValid;
    logic        FrameReady;
    logic        Overrun;

    ssd_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Segment   (Segment),
        .Digital   (Digital),
        .FrameData (FrameData),
        .FrameValid(FrameValid),
        .FrameReady(FrameReady),
        .Overrun   (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          errors = 0;
    int          checks = 0;
    int          xferCount = 0;
    logic [31:0] lastData = '0;
    logic [31:0] expQ[$];
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic [31:0] prevData = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] encodeNib(input logic [3:0] n);
        if (n <= 4'd9) return SEG_TAB[int'(n)];
        return 7'h7F;
    endfunction

    function automatic logic [4:0] decodeModel(input logic [6:0] code);
        for (int i = 0; i < 10; i++)
            if (SEG_TAB[i] == code) return {1'b0, 4'(i)};
        if (code == 7'h7F) return 5'h0F;
        return 5'h1E;
    endfunction

    // Word the display should be showing, given the six codes and DPs seen
    function automatic logic [31:0] modelWord(input logic [41:0] codes, input logic [5:0] dps);
        logic [31:0] w;
        logic [4:0]  d;
        w = '0;
        w[31] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = decodeModel(codes[7*i +: 7]);
            w[4*i +: 4] = d[3:0];
            w[30] = w[30] | d[4];
            w[24+i] = dps[i];
        end
        return w;
    endfunction

    function automatic logic [41:0] codesOf(input logic [31:0] w);
        logic [41:0] c;
        for (int i = 0; i < 6; i++) c[7*i +: 7] = encodeNib(w[4*i +: 4]);
        return c;
    endfunction

    task automatic driveDigit(input int idx, input logic [7:0] seg, input int cycles);
        Digital = ~(6'(1) << idx);
        Segment = seg;
        repeat (cycles) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic idle(input int cycles);
        Digital = '1;
        Segment = '1;
        repeat (cycles) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic scanCodes(input logic [41:0] codes, input logic [5:0] dps, input int glitchDigit);
        logic [7:0] seg;
        for (int i = 0; i < 6; i++) begin
            seg = {~dps[i], codes[7*i +: 7]};
            if (i == glitchDigit) begin
                driveDigit(i, seg, 50);
                driveDigit(i, 8'h80, 5);
                driveDigit(i, seg, SLOT - 55);
            end else begin
                driveDigit(i, seg, SLOT);
            end
        end
    endtask

    task automatic scanWord(input logic [31:0] w, input bit expectIt, input int glitchDigit);
        if (expectIt) expQ.push_back(modelWord(codesOf(w), w[29:24]));
        scanCodes(codesOf(w), w[29:24], glitchDigit);
    endtask

    task automatic waitDrain(input string name, input int budget);
        for (int k = 0; k < budget && expQ.size() != 0; k++) begin
            @(posedge Clock);
            #1;
        end
        check(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Every transfer is checked against the model queue; stalled output must hold
    always @(negedge Clock) begin
        if (Reset) begin
            if (prevValid && !prevReady) begin
                check("hold_data", FrameData, prevData);
                check("hold_valid", 32'(FrameValid), 32'd1);
            end
            if (FrameValid && FrameReady) begin
                xferCount++;
                lastData = FrameData;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %h expected no frame", FrameData);
                end else begin
                    check("frame", FrameData, expQ.pop_front());
                end
            end
            prevValid = FrameValid;
            prevReady = FrameReady;
            prevData  = FrameData;
        end else begin
            prevValid = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [41:0] codes;
        int          base;

        Reset      = 1'b0;
        Segment    = '1;
        Digital    = '1;
        FrameReady = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_data", FrameData, 32'h00FF_FFFF);
        check("rst_valid", 32'(FrameValid), 32'd0);
        check("rst_overrun", 32'(Overrun), 32'd0);
        Reset = 1'b1;
        @(posedge Clock);
        #1;

        // Continuous scans, consumer always ready
        for (int f = 0; f < 3; f++) scanWord(32'h8012_3456, 1'b1, -1);
        idle(10);
        waitDrain("drain_basic", 50);
        check("basic_word", lastData, 32'h8012_3456);
        check("basic_count", 32'(xferCount), 32'd3);

        // DP on digit 2, blank digit 5
        scanWord(32'h04F2_3456, 1'b1, -1);
        idle(10);
        waitDrain("drain_dp", 50);
        check("dp_blank_word", lastData, 32'h84F2_3456);

        // Illegal code on digit 3
        codes = codesOf(32'h0012_3456);
        codes[21 +: 7] = 7'h55;
        expQ.push_back(modelWord(codes, 6'b0));
        scanCodes(codes, 6'b0, -1);
        idle(10);
        waitDrain("drain_illegal", 50);
        check("illegal_word", lastData, 32'hC012_E456);

        // Short glitch on digit 2 is ignored
        base = xferCount;
        scanWord(32'h8012_3456, 1'b1, 2);
        idle(10);
        waitDrain("drain_glitch", 50);
        check("glitch_word", lastData, 32'h8012_3456);
        check("glitch_count", 32'(xferCount - base), 32'd1);

        // Out-of-order digits abort; only the following clean scan publishes
        base = xferCount;
        codes = codesOf(32'h0065_4321);
        driveDigit(0, {1'b1, codes[0 +: 7]}, SLOT);
        driveDigit(1, {1'b1, codes[7 +: 7]}, SLOT);
        driveDigit(3, {1'b1, codes[21 +: 7]}, SLOT);
        driveDigit(4, {1'b1, codes[28 +: 7]}, SLOT);
        driveDigit(5, {1'b1, codes[35 +: 7]}, SLOT);
        check("abort_none", 32'(xferCount - base), 32'd0);
        scanWord(32'h0065_4321, 1'b1, -1);
        idle(10);
        waitDrain("drain_abort", 50);
        check("abort_count", 32'(xferCount - base), 32'd1);
        check("abort_word", lastData, 32'h8065_4321);

        // Frozen select: a single disabled-display publish
        base = xferCount;
        expQ.push_back(32'h00FF_FFFF);
        driveDigit(0, 8'hFF, 2 * TIMEOUT + 500);
        idle(10);
        waitDrain("drain_timeout", 50);
        check("timeout_count", 32'(xferCount - base), 32'd1);
        check("timeout_word", lastData, 32'h00FF_FFFF);

        // Stalled consumer: first word held, second dropped with Overrun
        FrameReady = 1'b0;
        scanWord(32'h0065_4321, 1'b1, -1);
        scanWord(32'h0009_8877, 1'b0, -1);
        idle(10);
        check("stall_valid", 32'(FrameValid), 32'd1);
        check("stall_data", FrameData, 32'h8065_4321);
        check("stall_overrun", 32'(Overrun), 32'd1);
        FrameReady = 1'b1;
        @(posedge Clock);
        #1;
        check("release_overrun", 32'(Overrun), 32'd0);
        check("release_valid", 32'(FrameValid), 32'd0);
        waitDrain("drain_overrun", 10);

        // Reset asserted mid-capture loses the partial frame
        base = xferCount;
        codes = codesOf(32'h0012_3456);
        driveDigit(0, {1'b1, codes[0 +: 7]}, SLOT);
        driveDigit(1, {1'b1, codes[7 +: 7]}, SLOT);
        driveDigit(2, {1'b1, codes[14 +: 7]}, SLOT);
        driveDigit(3, {1'b1, codes[21 +: 7]}, 30);
        Reset = 1'b0;
        idle(5);
        check("midrst_data", FrameData, 32'h00FF_FFFF);
        check("midrst_valid", 32'(FrameValid), 32'd0);
        check("midrst_overrun", 32'(Overrun), 32'd0);
        Reset = 1'b1;
        idle(2);
        driveDigit(3, {1'b1, codes[21 +: 7]}, SLOT);
        driveDigit(4, {1'b1, codes[28 +: 7]}, SLOT);
        driveDigit(5, {1'b1, codes[35 +: 7]}, SLOT);
        check("midrst_none", 32'(xferCount - base), 32'd0);
        scanWord(32'h0012_3456, 1'b1, -1);
        idle(10);
        waitDrain("drain_midrst", 50);
        check("midrst_recover", lastData, 32'h8012_3456);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
